mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL provide clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL provide rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL provide bus_addr, input, 12, CPU address.
REQ-004 SHALL provide bus_data_rw, input, 1, CPU direction: 1 = write, 0 = read.
REQ-005 SHALL provide bus_data_out, input, 4, CPU write data.
REQ-006 SHALL provide bus_data_in, output, 4, read data returned to the CPU.
REQ-007 SHALL provide cpu_rst_n, output, 1, registered, active-low reset driven to the CPU.
REQ-008 SHALL provide gpio_out, output, 4, registered output port.
REQ-009 SHALL provide gpio_in, input, 4, asynchronous input port.
REQ-010 SHALL provide load_en, input, 1, program-load request from the host.
REQ-011 SHALL provide load_valid, input, 1, load nibble valid.
REQ-012 SHALL provide load_data, input, 4, load nibble.
REQ-013 SHALL provide load_ready, output, 1, load nibble accept.
REQ-014 SHALL provide load_wrap, output, 1, sticky flag: load pointer wrapped.

Function
REQ-015 Address map SHALL be: 0x000-0x0FF RAM (256x4); 0xFF0 gpio_out (read/write); 0xFF1 synchronized gpio_in (read-only); all other addresses read 4'h0, writes ignored.
REQ-016 Reads SHALL be combinational from bus_addr, so bus_data_in is valid in the same cycle the address is presented; the CPU samples it at the next edge.
REQ-017 A write SHALL commit at every rising edge where bus_data_rw=1 and state=RUN (last write wins); this tolerates the CPU's 2-cycle write with data arriving in the second cycle.
REQ-018 gpio_in SHALL pass through a 2-flop synchronizer; a read of 0xFF1 returns the second flop.
REQ-019 The FSM SHALL have the states HOLD, LOAD, DRAIN and RUN.
REQ-020 HOLD: cpu_rst_n=0; the next state is LOAD if load_en=1, else RUN.
REQ-021 LOAD: cpu_rst_n=0; load_ready = (state==LOAD && load_en), combinational.
REQ-022 In LOAD, each edge with load_valid && load_ready SHALL write load_data to RAM[ptr] and then increment ptr.
REQ-023 ptr SHALL be 8-bit and wrap from 0xFF to 0x00; the wrap SHALL set load_wrap, which stays set until the next LOAD entry.
REQ-024 In LOAD with load_en=0, the FSM SHALL go to DRAIN; a load_valid in that same cycle is not accepted.
REQ-025 DRAIN: cpu_rst_n=0 for exactly 2 cycles, then the FSM goes to RUN.
REQ-026 RUN: cpu_rst_n=1; if load_en=1, the next state is LOAD, and cpu_rst_n=0 from the next edge.
REQ-027 On every entry to LOAD, ptr SHALL be cleared to 0 and load_wrap cleared.
REQ-028 CPU bus writes in HOLD, LOAD or DRAIN SHALL be ignored.
REQ-029 bus_data_in SHALL follow the map in all states.

Reset
REQ-030 While rst_n=0, the following SHALL apply: state=HOLD, cpu_rst_n=0, gpio_out=0, ptr=0, load_wrap=0, sync flops=0, load_ready=0.
REQ-031 RAM contents SHALL NOT be reset.
REQ-032 A reset asserted mid-LOAD SHALL abort the load; already-written nibbles remain in RAM.
REQ-033 Deassertion of rst_n SHALL leave the FSM in HOLD for exactly 1 cycle.

Structure
REQ-034 The address-map constants (RAM_TOP, GPIO_OUT_ADDR, GPIO_IN_ADDR) and the FSM state encodings SHALL live in a shared package/header.
REQ-035 The RAM SHALL be a sub-module nibble_ram: 256x4, synchronous write, asynchronous read.
REQ-036 The RAM write port SHALL be muxed between the loader (in LOAD) and the CPU (in RUN).

Verification
REQ-037 Scenario: reset with load_en=0 -> HOLD for 1 cycle, then RUN; cpu_rst_n=1 on the 2nd edge after rst_n rises; gpio_out=0.
REQ-038 Scenario: load_en=1, stream nibbles 0x3,0x2,0x1 with valid continuous, then load_en=0 -> RAM[0..2]=3,2,1; cpu_rst_n low through 2 DRAIN cycles, then high.
REQ-039 Scenario: load 257 nibbles -> load_wrap=1; RAM[0] holds the 257th nibble.
REQ-040 Scenario: RUN, bus_addr=0xFF0, rw=1 for 2 cycles with data 0x9 in the 2nd -> gpio_out=0x9; reading 0xFF0 returns 0x9.
REQ-041 Scenario: gpio_in=0xA -> read of 0xFF1 returns 0xA from the 2nd edge after the change; read of 0x800 returns 0x0.
REQ-042 Scenario: rst_n pulled low mid-LOAD after 2 nibbles, then released with load_en=0 -> HOLD, then RUN; the 2 nibbles are retained; load_wrap=0.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared address map and FSM state encoding for the memory bus controller.
package mem_bus_ctrl_pkg;

    localparam logic [11:0] RAM_TOP       = 12'h0FF;
    localparam logic [11:0] GPIO_OUT_ADDR = 12'hFF0;
    localparam logic [11:0] GPIO_IN_ADDR  = 12'hFF1;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_bus_ctrl_nibble_ram.sv
// 256x4 RAM: synchronous write, asynchronous read, no reset on contents.
module nibble_ram (
    input  logic       clk,
    input  logic       i_we,
    input  logic [7:0] i_waddr,
    input  logic [3:0] i_wdata,
    input  logic [7:0] i_raddr,
    output logic [3:0] o_rdata
);

    logic [3:0] r_mem [0:255];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU memory/GPIO bus controller with host program loader and CPU reset sequencing.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bus_addr,
    input  logic        bus_data_rw,
    input  logic [3:0]  bus_data_out,
    output logic [3:0]  bus_data_in,
    output logic        cpu_rst_n,
    output logic [3:0]  gpio_out,
    input  logic [3:0]  gpio_in,
    input  logic        load_en,
    input  logic        load_valid,
    input  logic [3:0]  load_data,
    output logic        load_ready,
    output logic        load_wrap
);

    state_t      r_state;
    state_t      w_next;
    logic        r_drain_cnt;
    logic [7:0]  r_ptr;
    logic        r_wrap;
    logic [3:0]  r_gpio_out;
    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic        r_cpu_rst_n;

    logic        w_load_ready;
    logic        w_load_acc;
    logic        w_load_entry;
    logic        w_cpu_wr;
    logic        w_ram_we;
    logic [7:0]  w_ram_waddr;
    logic [3:0]  w_ram_wdata;
    logic [3:0]  w_ram_rdata;
    logic [3:0]  w_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HOLD:  w_next = load_en ? ST_LOAD : ST_RUN;
            ST_LOAD:  if (!load_en) w_next = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt) w_next = ST_RUN;
            ST_RUN:   if (load_en) w_next = ST_LOAD;
            default:  w_next = ST_HOLD;
        endcase
    end

    always_comb begin
        w_load_ready = (r_state == ST_LOAD) && load_en;
        w_load_acc   = w_load_ready && load_valid;
        w_load_entry = (w_next == ST_LOAD) && (r_state != ST_LOAD);
        w_cpu_wr     = (r_state == ST_RUN) && bus_data_rw;
        w_ram_we     = 1'b0;
        w_ram_waddr  = bus_addr[7:0];
        w_ram_wdata  = bus_data_out;
        if (r_state == ST_LOAD) begin
            w_ram_we    = w_load_acc;
            w_ram_waddr = r_ptr;
            w_ram_wdata = load_data;
        end else if (w_cpu_wr && (bus_addr <= RAM_TOP)) begin
            w_ram_we    = 1'b1;
        end
    end

    nibble_ram u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (bus_addr[7:0]),
        .o_rdata (w_ram_rdata)
    );

    // Leaving HOLD keeps the CPU in reset one extra cycle; elsewhere cpu_rst_n
    // rises on the same edge the FSM enters RUN and falls as it leaves RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= 1'b0;
            r_ptr       <= '0;
            r_wrap      <= 1'b0;
            r_gpio_out  <= '0;
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_drain_cnt <= (r_state == ST_DRAIN) ? ~r_drain_cnt : 1'b0;
            r_sync1     <= gpio_in;
            r_sync2     <= r_sync1;
            r_cpu_rst_n <= (w_next == ST_RUN) && (r_state != ST_HOLD);
            if (w_load_entry) begin
                r_ptr  <= '0;
                r_wrap <= 1'b0;
            end else if (w_load_acc) begin
                r_ptr <= r_ptr + 8'd1;
                if (r_ptr == 8'hFF) begin
                    r_wrap <= 1'b1;
                end
            end
            if (w_cpu_wr && (bus_addr == GPIO_OUT_ADDR)) begin
                r_gpio_out <= bus_data_out;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (bus_addr <= RAM_TOP) begin
            w_rdata = w_ram_rdata;
        end else if (bus_addr == GPIO_OUT_ADDR) begin
            w_rdata = r_gpio_out;
        end else if (bus_addr == GPIO_IN_ADDR) begin
            w_rdata = r_sync2;
        end
    end

    assign bus_data_in = w_rdata;
    assign cpu_rst_n   = r_cpu_rst_n;
    assign gpio_out    = r_gpio_out;
    assign load_ready  = w_load_ready;
    assign load_wrap   = r_wrap;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: scenario tasks with a read-data scoreboard.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        rst_n;
    logic [11:0] bus_addr;
    logic        bus_data_rw;
    logic [3:0]  bus_data_out;
    logic [3:0]  bus_data_in;
    logic        cpu_rst_n;
    logic [3:0]  gpio_out;
    logic [3:0]  gpio_in;
    logic        load_en;
    logic        load_valid;
    logic [3:0]  load_data;
    logic        load_ready;
    logic        load_wrap;

    int          n_checks;
    int          n_errors;
    logic [3:0]  exp_q [$];
    logic [3:0]  m_ram [0:255];

    mem_bus_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_addr     (bus_addr),
        .bus_data_rw  (bus_data_rw),
        .bus_data_out (bus_data_out),
        .bus_data_in  (bus_data_in),
        .cpu_rst_n    (cpu_rst_n),
        .gpio_out     (gpio_out),
        .gpio_in      (gpio_in),
        .load_en      (load_en),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .load_wrap    (load_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        load_en = 1'b1;
        #1;
        n_checks++;
        if (load_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_load_ready: got %b want 0", load_ready);
        end
        load_en = 1'b0;
        n_checks++;
        if (cpu_rst_n !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_cpu_rst_n: got %b want 0", cpu_rst_n);
        end
        n_checks++;
        if (gpio_out !== 4'h0) begin
            n_errors++;
            $display("FAIL rst_gpio_out: got %h want 0", gpio_out);
        end
        n_checks++;
        if (load_wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_load_wrap: got %b want 0", load_wrap);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (cpu_rst_n !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_cpu_rst_n: got %b want 0", cpu_rst_n);
        end
        tick();
        n_checks++;
        if (cpu_rst_n !== 1'b1) begin
            n_errors++;
            $display("FAIL run_cpu_rst_n: got %b want 1", cpu_rst_n);
        end
        n_checks++;
        if (gpio_out !== 4'h0) begin
            n_errors++;
            $display("FAIL run_gpio_out: got %h want 0", gpio_out);
        end
    endtask

    task automatic test_gpio();
        logic [3:0] exp;
        bus_addr     = 12'hFF0;
        bus_data_rw  = 1'b1;
        bus_data_out = 4'h6;
        tick();
        bus_data_out = 4'h9;
        tick();
        bus_data_rw = 1'b0;
        n_checks++;
        if (gpio_out !== 4'h9) begin
            n_errors++;
            $display("FAIL gpio_out_write: got %h want 9", gpio_out);
        end
        exp_q.push_back(4'h9);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (bus_data_in !== exp) begin
            n_errors++;
            $display("FAIL rd_ff0: got %h want %h", bus_data_in, exp);
        end
        bus_addr     = 12'h005;
        bus_data_rw  = 1'b1;
        bus_data_out = 4'hC;
        m_ram[5]     = 4'hC;
        tick();
        bus_data_rw = 1'b0;
        exp_q.push_back(m_ram[5]);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (bus_data_in !== exp) begin
            n_errors++;
            $display("FAIL rd_ram_cpu_wr: got %h want %h", bus_data_in, exp);
        end
        gpio_in  = 4'hA;
        bus_addr = 12'hFF1;
        tick();
        exp_q.push_back(4'h0);
        exp = exp_q.pop_front();
        n_checks++;
        if (bus_data_in !== exp) begin
            n_errors++;
            $display("FAIL rd_ff1_edge1: got %h want %h", bus_data_in, exp);
        end
        tick();
        exp_q.push_back(4'hA);
        exp = exp_q.pop_front();
        n_checks++;
        if (bus_data_in !== exp) begin
            n_errors++;
            $display("FAIL rd_ff1_edge2: got %h want %h", bus_data_in, exp);
        end
        bus_addr     = 12'h800;
        bus_data_rw  = 1'b1;
        bus_data_out = 4'hF;
        tick();
        bus_data_rw = 1'b0;
        exp_q.push_back(4'h0);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (bus_data_in !== exp) begin
            n_errors++;
            $display("FAIL rd_unmapped: got %h want %h", bus_data_in, exp);
        end
        n_checks++;
        if (gpio_out !== 4'h9) begin
            n_errors++;
            $display("FAIL gpio_out_unmapped_wr: got %h want 9", gpio_out);
        end
    endtask

    task automatic test_load();
        logic [3:0] exp;
        logic [3:0] seq [3];
        seq[0] = 4'h3;
        seq[1] = 4'h2;
        seq[2] = 4'h1;
        load_en = 1'b1;
        #1;
        n_checks++;
        if (load_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL load_ready_in_run: got %b want 0", load_ready);
        end
        tick();
        n_checks++;
        if (cpu_rst_n !== 1'b0) begin
            n_errors++;
            $display("FAIL load_cpu_rst_n: got %b want 0", cpu_rst_n);
        end
        n_checks++;
        if (load_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL load_ready: got %b want 1", load_ready);
        end
        bus_addr     = 12'hFF0;
        bus_data_rw  = 1'b1;
        bus_data_out = 4'h5;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = seq[i];
            m_ram[i]   = seq[i];
            tick();
        end
        load_en   = 1'b0;
        load_data = 4'hF;
        #1;
        n_checks++;
        if (load_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL load_ready_exit: got %b want 0", load_ready);
        end
        tick();
        load_valid  = 1'b0;
        n_checks++;
        if (cpu_rst_n !== 1'b0) begin
            n_errors++;
            $display("FAIL drain1_cpu_rst_n: got %b want 0", cpu_rst_n);
        end
        tick();
        bus_data_rw = 1'b0;
        n_checks++;
        if (cpu_rst_n !== 1'b0) begin
            n_errors++;
            $display("FAIL drain2_cpu_rst_n: got %b want 0", cpu_rst_n);
        end
        tick();
        n_checks++;
        if (cpu_rst_n !== 1'b1) begin
            n_errors++;
            $display("FAIL after_drain_cpu_rst_n: got %b want 1", cpu_rst_n);
        end
        n_checks++;
        if (gpio_out !== 4'h9) begin
            n_errors++;
            $display("FAIL gpio_wr_ignored_in_load: got %h want 9", gpio_out);
        end
        for (int a = 0; a < 6; a++) begin
            if (a == 3 || a == 4) continue;
            bus_addr = 12'(a);
            exp_q.push_back(m_ram[a]);
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if (bus_data_in !== exp) begin
                n_errors++;
                $display("FAIL load_ram[%0d]: got %h want %h", a, bus_data_in, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp;
        logic [3:0] d;
        int         rd_addr [4];
        rd_addr[0] = 0;
        rd_addr[1] = 1;
        rd_addr[2] = 2;
        rd_addr[3] = 255;
        load_en = 1'b1;
        tick();
        for (int i = 0; i < 257; i++) begin
            d           = 4'(i * 7 + 3);
            m_ram[i % 256] = d;
            load_valid  = 1'b1;
            load_data   = d;
            tick();
            if (i == 254) begin
                n_checks++;
                if (load_wrap !== 1'b0) begin
                    n_errors++;
                    $display("FAIL wrap_early: got %b want 0", load_wrap);
                end
            end
        end
        n_checks++;
        if (load_wrap !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_set: got %b want 1", load_wrap);
        end
        load_en   = 1'b0;
        load_data = ~m_ram[1];
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (cpu_rst_n !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_run_cpu_rst_n: got %b want 1", cpu_rst_n);
        end
        n_checks++;
        if (load_wrap !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_sticky: got %b want 1", load_wrap);
        end
        for (int k = 0; k < 4; k++) begin
            bus_addr = 12'(rd_addr[k]);
            exp_q.push_back(m_ram[rd_addr[k]]);
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if (bus_data_in !== exp) begin
                n_errors++;
                $display("FAIL wrap_ram[%0d]: got %h want %h", rd_addr[k], bus_data_in, exp);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [3:0] exp;
        load_en = 1'b1;
        tick();
        n_checks++;
        if (load_wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_clear_on_entry: got %b want 0", load_wrap);
        end
        load_valid = 1'b1;
        load_data  = 4'hE;
        m_ram[0]   = 4'hE;
        tick();
        load_data  = 4'hD;
        m_ram[1]   = 4'hD;
        tick();
        load_data = 4'h7;
        rst_n     = 1'b0;
        #1;
        n_checks++;
        if (load_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_load_ready: got %b want 0", load_ready);
        end
        n_checks++;
        if (cpu_rst_n !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_cpu_rst_n: got %b want 0", cpu_rst_n);
        end
        n_checks++;
        if (gpio_out !== 4'h0) begin
            n_errors++;
            $display("FAIL midrst_gpio_out: got %h want 0", gpio_out);
        end
        load_en    = 1'b0;
        load_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (cpu_rst_n !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_hold_cpu_rst_n: got %b want 0", cpu_rst_n);
        end
        tick();
        n_checks++;
        if (cpu_rst_n !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_run_cpu_rst_n: got %b want 1", cpu_rst_n);
        end
        n_checks++;
        if (load_wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_load_wrap: got %b want 0", load_wrap);
        end
        for (int a = 0; a < 3; a++) begin
            bus_addr = 12'(a);
            exp_q.push_back(m_ram[a]);
            #1;
            exp = exp_q.pop_front();
            n_checks++;
            if (bus_data_in !== exp) begin
                n_errors++;
                $display("FAIL midrst_ram[%0d]: got %h want %h", a, bus_data_in, exp);
            end
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus_addr     = '0;
        bus_data_rw  = 1'b0;
        bus_data_out = '0;
        gpio_in      = '0;
        load_en      = 1'b0;
        load_valid   = 1'b0;
        load_data    = '0;
        test_reset();
        test_gpio();
        test_load();
        test_wrap();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
